sm_irq_ctrl: RTL and testbench

- Memory-mapped hardware interrupt controller for the schoolMIPS single-cycle core.
- Collects N_IRQ asynchronous external interrupt sources and applies a per-source edge or level mode and a per-source mask.
- Drives the single registered request line that feeds the CP0 hardware interrupt input IP2.
- Software reads it, identifies and acknowledges sources through four word registers on the data bus.

---
 rtl/sm_irq_ctrl_pkg.sv | 24 ++
 rtl/sm_irq_ctrl_if.sv | 31 +++
 rtl/sm_irq_sync.sv | 38 +++
 rtl/sm_irq_ctrl.sv | 121 ++++++++++++
 tb/tb_sm_irq_ctrl.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/sm_irq_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// sm_irq_ctrl_pkg : register offsets and shared types for the IRQ controller
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package sm_irq_ctrl_pkg;

  localparam int SM_IRQ_REG_PENDING  = 0;
  localparam int SM_IRQ_REG_MASK     = 1;
  localparam int SM_IRQ_REG_EDGE     = 2;
  localparam int SM_IRQ_REG_ID       = 3;
  localparam int SM_IRQ_ID_VALID_BIT = 31;

  typedef enum logic [1:0] {
    REG_PENDING = 2'(SM_IRQ_REG_PENDING),
    REG_MASK    = 2'(SM_IRQ_REG_MASK),
    REG_EDGE    = 2'(SM_IRQ_REG_EDGE),
    REG_ID      = 2'(SM_IRQ_REG_ID)
  } reg_sel_e;

endpackage

`default_nettype wire

// File: rtl/sm_irq_ctrl_if.sv
// ---------------------------------------------------------------------------
// sm_irq_ctrl_if : word-register data bus between the core and the controller
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface sm_irq_ctrl_if;
  logic        bus_sel;
  logic [3:0]  bus_addr;
  logic        bus_we;
  logic [31:0] bus_wd;
  logic [31:0] bus_rd;

  modport master (
    output bus_sel,
    output bus_addr,
    output bus_we,
    output bus_wd,
    input  bus_rd
  );

  modport slave (
    input  bus_sel,
    input  bus_addr,
    input  bus_we,
    input  bus_wd,
    output bus_rd
  );
endinterface

`default_nettype wire

// File: rtl/sm_irq_sync.sv
// ---------------------------------------------------------------------------
// sm_irq_sync : per-source 2-flop synchroniser plus history flop for edges
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sm_irq_sync #(
  parameter int N_IRQ = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] irq_in,
  output logic [N_IRQ-1:0] sync_o,
  output logic [N_IRQ-1:0] rise_o
);

  logic [N_IRQ-1:0] meta_q;
  logic [N_IRQ-1:0] sync_q;
  logic [N_IRQ-1:0] prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      meta_q <= irq_in;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync_o = sync_q;
  assign rise_o = sync_q & ~prev_q;

endmodule

`default_nettype wire

// File: rtl/sm_irq_ctrl.sv
// ---------------------------------------------------------------------------
// sm_irq_ctrl : memory-mapped interrupt controller driving CP0 IP2
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sm_irq_ctrl
  import sm_irq_ctrl_pkg::*;
#(
  parameter int N_IRQ = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_IRQ-1:0]   irq_in,
  sm_irq_ctrl_if.slave       bus,
  output logic               irq_out
);

  logic [N_IRQ-1:0] sync_w;
  logic [N_IRQ-1:0] rise_w;

  sm_irq_sync #(.N_IRQ(N_IRQ)) u_sync (
    .clk    (clk),
    .rst    (rst),
    .irq_in (irq_in),
    .sync_o (sync_w),
    .rise_o (rise_w)
  );

  logic [N_IRQ-1:0] pend_q, pend_d;
  logic [N_IRQ-1:0] mask_q, mask_d;
  logic [N_IRQ-1:0] edge_q, edge_d;
  logic [N_IRQ-1:0] clr_w;
  logic [N_IRQ-1:0] act_w;
  logic             irq_q, irq_d;
  logic             wr_w;
  reg_sel_e         reg_w;
  logic [N_IRQ-1:0] wd_w;
  logic [31:0]      id_w;
  logic             unused_bus_bits;

  assign reg_w = reg_sel_e'(bus.bus_addr[3:2]);
  assign wr_w  = bus.bus_sel & bus.bus_we;
  assign wd_w  = bus.bus_wd[N_IRQ-1:0];
  assign act_w = pend_q & mask_q;

  assign unused_bus_bits = ^{bus.bus_addr[1:0], bus.bus_wd[31:N_IRQ]};

  function automatic logic [3:0] lowest_idx(input logic [N_IRQ-1:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  function automatic logic [31:0] zext(input logic [N_IRQ-1:0] v);
    logic [31:0] r;
    r = '0;
    r[N_IRQ-1:0] = v;
    return r;
  endfunction

  always_comb begin
    mask_d = mask_q;
    edge_d = edge_q;
    clr_w  = '0;
    if (wr_w) begin
      case (reg_w)
        REG_PENDING: clr_w  = wd_w;
        REG_MASK:    mask_d = wd_w;
        REG_EDGE:    edge_d = wd_w;
        default:     ;
      endcase
    end
    // Edge sources: a rise always beats a same-cycle clear. A source just
    // switched into edge mode starts empty unless it rises on that edge.
    pend_d = (edge_q & (rise_w | (pend_q & ~clr_w)))
           | (~edge_q & edge_d & rise_w)
           | (~edge_q & ~edge_d & sync_w);
    irq_d  = |(pend_d & mask_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= '0;
      mask_q <= '0;
      edge_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      mask_q <= mask_d;
      edge_q <= edge_d;
      irq_q  <= irq_d;
    end
  end

  assign irq_out = irq_q;

  always_comb begin
    id_w                      = '0;
    id_w[SM_IRQ_ID_VALID_BIT] = |act_w;
    id_w[3:0]                 = lowest_idx(act_w);
  end

  always_comb begin
    bus.bus_rd = '0;
    if (bus.bus_sel) begin
      case (reg_w)
        REG_PENDING: bus.bus_rd = zext(pend_q);
        REG_MASK:    bus.bus_rd = zext(mask_q);
        REG_EDGE:    bus.bus_rd = zext(edge_q);
        default:     bus.bus_rd = id_w;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sm_irq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sm_irq_ctrl : scoreboard bench with a cycle-level behavioural model
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_sm_irq_ctrl;

  localparam int N_IRQ = 8;
  localparam logic [3:0] A_PEND = 4'h0;
  localparam logic [3:0] A_MASK = 4'h4;
  localparam logic [3:0] A_EDGE = 4'h8;
  localparam logic [3:0] A_ID   = 4'hC;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [N_IRQ-1:0] irq_v = '0;
  logic             irq_out;

  sm_irq_ctrl_if bus_if ();

  sm_irq_ctrl #(.N_IRQ(N_IRQ)) dut (
    .clk     (clk),
    .rst     (rst),
    .irq_in  (irq_v),
    .bus     (bus_if.slave),
    .irq_out (irq_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rd;
    logic        irq;
    string       tag;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   passed = 0;

  // Reference state: registers as software sees them, plus the raw input
  // history (h0 newest sample). A source is seen two samples late.
  logic [7:0] m_pend = '0, m_mask = '0, m_edge = '0;
  logic       m_irq = 1'b0;
  logic [7:0] h0 = '0, h1 = '0, h2 = '0;

  logic       g_rst = 1'b1;
  logic [7:0] g_irq = '0;

  function automatic logic [31:0] model_read(input logic sel, input logic [3:0] addr);
    logic [31:0] r;
    logic [7:0]  act;
    r = '0;
    if (!sel) return r;
    case (addr[3:2])
      2'd0: r[7:0] = m_pend;
      2'd1: r[7:0] = m_mask;
      2'd2: r[7:0] = m_edge;
      default: begin
        act = m_pend & m_mask;
        if (act != 0) begin
          r[31] = 1'b1;
          for (int i = 7; i >= 0; i--) if (act[i]) r[3:0] = i[3:0];
        end
      end
    endcase
    return r;
  endfunction

  task automatic model_reset();
    m_pend = '0; m_mask = '0; m_edge = '0; m_irq = 1'b0;
    h0 = '0; h1 = '0; h2 = '0;
  endtask

  task automatic model_step();
    logic [7:0] nm, ne, clr, np, sy, ri;
    logic       wr;
    if (rst) begin
      model_reset();
      return;
    end
    sy = h1;
    ri = h1 & ~h2;
    wr = bus_if.bus_sel & bus_if.bus_we;
    nm = (wr && bus_if.bus_addr[3:2] == 2'd1) ? bus_if.bus_wd[7:0] : m_mask;
    ne = (wr && bus_if.bus_addr[3:2] == 2'd2) ? bus_if.bus_wd[7:0] : m_edge;
    clr = (wr && bus_if.bus_addr[3:2] == 2'd0) ? bus_if.bus_wd[7:0] : 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (m_edge[i])      np[i] = ri[i] ? 1'b1 : (clr[i] ? 1'b0 : m_pend[i]);
      else if (ne[i])     np[i] = ri[i];
      else                np[i] = sy[i];
    end
    m_irq  = (np & nm) != 0;
    m_pend = np;
    m_mask = nm;
    m_edge = ne;
    h2 = h1; h1 = h0; h0 = irq_v;
  endtask

  task automatic cyc(input logic [7:0] irq, input logic sel, input logic [3:0] addr,
                     input logic we, input logic [31:0] wd, input string tag);
    exp_t e;
    @(posedge clk);
    model_step();
    #1;
    rst              = g_rst;
    irq_v            = irq;
    bus_if.bus_sel   = sel;
    bus_if.bus_addr  = addr;
    bus_if.bus_we    = we;
    bus_if.bus_wd    = wd;
    if (rst) model_reset();
    e.rd  = model_read(sel, addr);
    e.irq = m_irq;
    e.tag = tag;
    sbq.push_back(e);
  endtask

  task automatic wr(input logic [3:0] addr, input logic [31:0] d, input string tag);
    cyc(g_irq, 1'b1, addr | 4'($urandom_range(0, 3)), 1'b1, d, tag);
  endtask

  task automatic rd(input logic [3:0] addr, input string tag);
    cyc(g_irq, 1'b1, addr | 4'($urandom_range(0, 3)), 1'b0, $urandom, tag);
  endtask

  // Reset lands mid-cycle; outputs must already be cleared before the next edge.
  task automatic async_reset();
    exp_t e;
    @(posedge clk);
    model_step();
    #1;
    bus_if.bus_sel  = 1'b1;
    bus_if.bus_addr = A_PEND;
    bus_if.bus_we   = 1'b0;
    #1;
    g_rst = 1'b1;
    rst   = 1'b1;
    model_reset();
    e.rd  = model_read(1'b1, A_PEND);
    e.irq = m_irq;
    e.tag = "async_reset";
    sbq.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        checks++;
        if (bus_if.bus_rd === e.rd) passed++;
        else $display("FAIL %s bus_rd: got %h expected %h", e.tag, bus_if.bus_rd, e.rd);
        checks++;
        if (irq_out === e.irq) passed++;
        else $display("FAIL %s irq_out: got %b expected %b", e.tag, irq_out, e.irq);
      end
    end
  end

  initial begin : stimulus
    bus_if.bus_sel  = 1'b0;
    bus_if.bus_addr = '0;
    bus_if.bus_we   = 1'b0;
    bus_if.bus_wd   = '0;

    g_rst = 1'b1;
    rd(A_PEND, "rst_pend"); rd(A_MASK, "rst_mask"); rd(A_EDGE, "rst_edge"); rd(A_ID, "rst_id");
    g_rst = 1'b0;
    rd(A_PEND, "post_rst");

    wr(A_MASK, 32'h08, "edge_mask"); wr(A_EDGE, 32'h08, "edge_cfg");
    g_irq = 8'h08; rd(A_PEND, "edge_pulse"); g_irq = 8'h00;
    repeat (4) rd(A_PEND, "edge_wait");
    rd(A_ID, "edge_id");
    wr(A_PEND, 32'h08, "edge_w1c");
    rd(A_ID, "edge_id_clr"); rd(A_PEND, "edge_pend_clr");

    wr(A_MASK, 32'h02, "sbc_mask"); wr(A_EDGE, 32'h0A, "sbc_cfg");
    g_irq = 8'h02; rd(A_PEND, "sbc_p1"); g_irq = 8'h00;
    repeat (3) rd(A_PEND, "sbc_wait");
    g_irq = 8'h02; rd(A_PEND, "sbc_p2"); g_irq = 8'h00;
    rd(A_PEND, "sbc_gap");
    wr(A_PEND, 32'h02, "sbc_w1c");
    rd(A_PEND, "sbc_kept"); rd(A_PEND, "sbc_kept2");

    wr(A_EDGE, 32'h00, "lvl_cfg"); wr(A_MASK, 32'h01, "lvl_mask");
    g_irq = 8'h01;
    repeat (4) rd(A_PEND, "lvl_hold");
    wr(A_PEND, 32'h01, "lvl_w1c");
    rd(A_PEND, "lvl_after_w1c"); rd(A_PEND, "lvl_after_w1c2");
    g_irq = 8'h00;
    repeat (4) rd(A_PEND, "lvl_drop");

    wr(A_MASK, 32'h00, "pri_mask0"); wr(A_EDGE, 32'hFF, "pri_cfg");
    g_irq = 8'h44; rd(A_PEND, "pri_pulse"); g_irq = 8'h00;
    repeat (3) rd(A_PEND, "pri_wait");
    wr(A_MASK, 32'h40, "pri_mask40"); rd(A_ID, "pri_id6");
    wr(A_MASK, 32'h44, "pri_mask44"); rd(A_ID, "pri_id2");

    wr(A_MASK, 32'hFFFF_FFFF, "wid_mask"); rd(A_MASK, "wid_read");
    cyc(g_irq, 1'b0, A_MASK, 1'b1, 32'h0000_0000, "wid_nosel");
    rd(A_MASK, "wid_nosel_wr");

    wr(A_EDGE, 32'h05, "mr_cfg"); wr(A_MASK, 32'h05, "mr_mask");
    g_irq = 8'h05; rd(A_PEND, "mr_pulse"); g_irq = 8'h00;
    repeat (3) rd(A_PEND, "mr_wait");
    async_reset();
    rd(A_MASK, "mr_mask_rst"); rd(A_EDGE, "mr_edge_rst"); rd(A_ID, "mr_id_rst");
    g_rst = 1'b0;
    rd(A_MASK, "mr_mask_rel"); rd(A_EDGE, "mr_edge_rel");

    for (int n = 0; n < 3000; n++) begin
      logic [7:0]  flip;
      logic        sel, we;
      logic [3:0]  addr;
      flip = ($urandom_range(0, 2) == 0) ? 8'($urandom & $urandom) : 8'h00;
      g_irq = g_irq ^ flip;
      sel   = ($urandom_range(0, 4) != 0);
      we    = ($urandom_range(0, 2) == 0);
      addr  = 4'($urandom);
      cyc(g_irq, sel, addr, we, $urandom, "random");
    end

    repeat (3) @(negedge clk);
    checks++;
    if (sbq.size() == 0) passed++;
    else $display("FAIL scoreboard_drain: got %0d left expected 0", sbq.size());
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

`default_nettype wire
